unified_buffer_mp: RTL and testbench

- Parametrised multi-port successor of the single-bank unified buffer, sitting between the host/DMA load path and the systolic array feeders.
- Each of NUM_RD read ports has its own stream engine. A command (base, length, stride) is accepted and the engine generates the address sequence and the first/last markers internally.
- One byte-enabled write port.
- Read latency is parametrised, and a valid strobe accompanies every output beat.

---
 rtl/unified_buffer_mp_if.sv | 44 ++++
 rtl/unified_buffer_mp.sv | 168 ++++++++++++++++
 tb/tb_unified_buffer_mp.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/unified_buffer_mp_if.sv
// Bus bundle for unified_buffer_mp: the byte-enabled write port plus the
// per-port stream command, flow-control and read-beat signals.
//   master : host/DMA and feeder side (drives writes, commands, pause, abort)
//   slave  : buffer side (returns cmd_ready, busy and the read beats)
// Per-port vectors pack port p at [p*W +: W].
interface unified_buffer_mp_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned NUM_RD     = 2,
  parameter int unsigned LEN_WIDTH  = 16
);
  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  logic                             wr_en;
  logic [ADDR_WIDTH-1:0]            wr_addr;
  logic [DATA_WIDTH-1:0]            wr_data;
  logic [BE_WIDTH-1:0]              wr_be;

  logic [NUM_RD-1:0]                cmd_valid;
  logic [NUM_RD-1:0]                cmd_ready;
  logic [NUM_RD*ADDR_WIDTH-1:0]     cmd_base;
  logic [NUM_RD*LEN_WIDTH-1:0]      cmd_len;
  logic [NUM_RD*ADDR_WIDTH-1:0]     cmd_stride;
  logic [NUM_RD-1:0]                cmd_abort;
  logic [NUM_RD-1:0]                pause;
  logic [NUM_RD-1:0]                busy;

  logic [NUM_RD-1:0]                rd_valid;
  logic [NUM_RD-1:0]                rd_first;
  logic [NUM_RD-1:0]                rd_last;
  logic [NUM_RD*DATA_WIDTH-1:0]     rd_data;

  modport master (
    output wr_en, wr_addr, wr_data, wr_be,
    output cmd_valid, cmd_base, cmd_len, cmd_stride, cmd_abort, pause,
    input  cmd_ready, busy, rd_valid, rd_first, rd_last, rd_data
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_be,
    input  cmd_valid, cmd_base, cmd_len, cmd_stride, cmd_abort, pause,
    output cmd_ready, busy, rd_valid, rd_first, rd_last, rd_data
  );
endinterface

// File: rtl/unified_buffer_mp.sv
// Multi-port unified buffer: one byte-enabled write port and NUM_RD
// independent read stream engines. Each engine accepts (base, len, stride),
// walks the rows modulo DEPTH and emits beats with first/last markers after
// RD_LATENCY cycles.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset (engines and read pipes only)
//   bus  - unified_buffer_mp_if.slave (write port, commands, read beats)
// Build option:
//   UB_WR_BYPASS_EN - defined: a read of the row being written in the same
//                     cycle returns the merged new data (write-first);
//                     undefined: it returns the old row (read-first).
module unified_buffer_mp #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
  parameter int unsigned NUM_RD     = 2,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned RD_LATENCY = 1,
  parameter string       INIT_FILE  = ""
) (
  input  logic               clk,
  input  logic               rst,
  unified_buffer_mp_if.slave bus
);
  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Out-of-range write rows only exist when DEPTH is not a power of two.
  logic wr_hit;
  if ((2 ** ADDR_WIDTH) > DEPTH) begin : g_wr_range
    assign wr_hit = bus.wr_en && ({1'b0, bus.wr_addr} < (ADDR_WIDTH+1)'(DEPTH));
  end else begin : g_wr_full
    assign wr_hit = bus.wr_en;
  end

  // Byte-masked write; memory is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_hit) begin
      for (int i = 0; i < BE_WIDTH; i++) begin
        if (bus.wr_be[i]) mem[bus.wr_addr][8*i +: 8] <= bus.wr_data[8*i +: 8];
      end
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_port
    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cur_q, cur_d;
    logic [ADDR_WIDTH-1:0] stride_q, stride_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  issue, iss_first, iss_last;
    logic [DATA_WIDTH-1:0] row;

    logic [ADDR_WIDTH-1:0] cmd_base, cmd_stride;
    logic [LEN_WIDTH-1:0]  cmd_len;
    assign cmd_base   = bus.cmd_base[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign cmd_stride = bus.cmd_stride[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign cmd_len    = bus.cmd_len[g*LEN_WIDTH +: LEN_WIDTH];

    // Addressed row, optionally merged with a same-cycle write.
    always_comb begin
      row = mem[cur_q];
`ifdef UB_WR_BYPASS_EN
      if (wr_hit && (bus.wr_addr == cur_q)) begin
        for (int i = 0; i < BE_WIDTH; i++) begin
          if (bus.wr_be[i]) row[8*i +: 8] = bus.wr_data[8*i +: 8];
        end
      end
`endif
    end

    // Stream engine next-state and issue decode.
    always_comb begin
      state_d   = state_q;
      cur_d     = cur_q;
      stride_d  = stride_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      issue     = 1'b0;
      iss_first = 1'b0;
      iss_last  = 1'b0;
      if (bus.cmd_abort[g]) begin
        state_d = IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            // Zero-length commands are accepted and dropped.
            if (bus.cmd_valid[g] && (cmd_len != '0)) begin
              cur_d    = ADDR_WIDTH'({1'b0, cmd_base} % (ADDR_WIDTH+1)'(DEPTH));
              stride_d = cmd_stride;
              len_d    = cmd_len;
              cnt_d    = '0;
              state_d  = RUN;
            end
          end
          RUN: begin
            if (!bus.pause[g]) begin
              issue     = 1'b1;
              iss_first = (cnt_q == '0);
              iss_last  = (cnt_q == (len_q - LEN_WIDTH'(1)));
              cur_d     = ADDR_WIDTH'(({1'b0, cur_q} + {1'b0, stride_q})
                                      % (ADDR_WIDTH+1)'(DEPTH));
              cnt_d     = cnt_q + LEN_WIDTH'(1);
              if (iss_last) state_d = IDLE;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q  <= IDLE;
        cur_q    <= '0;
        stride_q <= '0;
        len_q    <= '0;
        cnt_q    <= '0;
      end else begin
        state_q  <= state_d;
        cur_q    <= cur_d;
        stride_q <= stride_d;
        len_q    <= len_d;
        cnt_q    <= cnt_d;
      end
    end

    // Read pipeline: stage 0 captures the issued row, last stage is the output.
    logic [RD_LATENCY-1:0] pv_q, pf_q, pl_q;
    logic [DATA_WIDTH-1:0] pd_q [RD_LATENCY];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pv_q <= '0;
        pf_q <= '0;
        pl_q <= '0;
        for (int k = 0; k < RD_LATENCY; k++) pd_q[k] <= '0;
      end else if (bus.cmd_abort[g]) begin
        // Kill every in-flight beat; data registers keep their last value.
        pv_q <= '0;
        pf_q <= '0;
        pl_q <= '0;
      end else begin
        pv_q[0] <= issue;
        pf_q[0] <= iss_first;
        pl_q[0] <= iss_last;
        if (issue) pd_q[0] <= row;
        for (int k = 1; k < RD_LATENCY; k++) begin
          pv_q[k] <= pv_q[k-1];
          pf_q[k] <= pf_q[k-1];
          pl_q[k] <= pl_q[k-1];
          if (pv_q[k-1]) pd_q[k] <= pd_q[k-1];
        end
      end
    end

    assign bus.cmd_ready[g] = (state_q == IDLE);
    assign bus.busy[g]      = (state_q == RUN) || (|pv_q);
    assign bus.rd_valid[g]  = pv_q[RD_LATENCY-1];
    assign bus.rd_first[g]  = pf_q[RD_LATENCY-1];
    assign bus.rd_last[g]   = pl_q[RD_LATENCY-1];
    assign bus.rd_data[g*DATA_WIDTH +: DATA_WIDTH] = pd_q[RD_LATENCY-1];
  end
endmodule

// File: tb/tb_unified_buffer_mp.sv
// Directed bench for unified_buffer_mp: ub1 runs RD_LATENCY=1, ub3 runs
// RD_LATENCY=3. A monitor logs every output beat; the initial block drives
// stimulus on falling edges and checks logged beats against a memory model.
module tb_unified_buffer_mp;
  localparam int unsigned DW = 64;
  localparam int unsigned AW = 8;
  localparam int unsigned NR = 2;
  localparam int unsigned LW = 16;
  localparam int unsigned DEPTH = 256;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  unified_buffer_mp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .LEN_WIDTH(LW)) ub1 ();
  unified_buffer_mp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .LEN_WIDTH(LW)) ub3 ();

  unified_buffer_mp #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .NUM_RD(NR),
                      .LEN_WIDTH(LW), .RD_LATENCY(1), .INIT_FILE(""))
    dut1 (.clk(clk), .rst(rst), .bus(ub1.slave));

  unified_buffer_mp #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .NUM_RD(NR),
                      .LEN_WIDTH(LW), .RD_LATENCY(3), .INIT_FILE(""))
    dut3 (.clk(clk), .rst(rst), .bus(ub3.slave));

  typedef struct packed {
    logic [63:0] data;
    logic        first;
    logic        last;
    logic [31:0] cyc;
  } beat_t;

  beat_t q0[$];
  beat_t q1[$];
  beat_t q3[$];
  beat_t qc[$];
  logic [31:0] cyc = 32'd0;
  logic [63:0] mdl [DEPTH];
  int vecs = 0;
  int errs = 0;

  // Beat logger, sampled 2 time units after each rising edge.
  always begin
    @(posedge clk);
    #2;
    cyc = cyc + 32'd1;
    if (ub1.rd_valid[0] === 1'b1) q0.push_back('{ub1.rd_data[63:0], ub1.rd_first[0], ub1.rd_last[0], cyc});
    if (ub1.rd_valid[1] === 1'b1) q1.push_back('{ub1.rd_data[127:64], ub1.rd_first[1], ub1.rd_last[1], cyc});
    if (ub3.rd_valid[0] === 1'b1) q3.push_back('{ub3.rd_data[63:0], ub3.rd_first[0], ub3.rd_last[0], cyc});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write the same row into both DUTs and the model; called at a falling edge.
  task automatic wr(input logic [7:0] a, input logic [63:0] d, input logic [7:0] be);
    ub1.wr_en = 1'b1; ub1.wr_addr = a; ub1.wr_data = d; ub1.wr_be = be;
    ub3.wr_en = 1'b1; ub3.wr_addr = a; ub3.wr_data = d; ub3.wr_be = be;
    for (int i = 0; i < 8; i++) if (be[i]) mdl[a][8*i +: 8] = d[8*i +: 8];
    @(negedge clk);
    ub1.wr_en = 1'b0;
    ub3.wr_en = 1'b0;
  endtask

  task automatic cmd1(input int p, input logic [7:0] base, input logic [15:0] len, input logic [7:0] stride);
    ub1.cmd_valid[p] = 1'b1;
    ub1.cmd_base[p*8 +: 8] = base;
    ub1.cmd_len[p*16 +: 16] = len;
    ub1.cmd_stride[p*8 +: 8] = stride;
  endtask

  task automatic cmd3(input logic [7:0] base, input logic [15:0] len, input logic [7:0] stride);
    ub3.cmd_valid[0] = 1'b1;
    ub3.cmd_base[7:0] = base;
    ub3.cmd_len[15:0] = len;
    ub3.cmd_stride[7:0] = stride;
  endtask

  task automatic wait_idle(input string tag, input int maxc);
    int n = 0;
    while (((ub1.busy | ub3.busy) != 2'b00) && (n < maxc)) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(ub1.busy | ub3.busy), 64'd0);
  endtask

  // Compare the logged beats in qc against the model walk base, base+stride, ...
  task automatic chk_stream(input string tag, input logic [7:0] base, input int len, input logic [7:0] stride);
    logic [7:0] a = base;
    chk({tag, " count"}, 64'(qc.size()), 64'(len));
    for (int i = 0; (i < len) && (i < int'(qc.size())); i++) begin
      chk({tag, " data"}, qc[i].data, mdl[a]);
      chk({tag, " marks"}, {62'd0, qc[i].first, qc[i].last}, {62'd0, (i == 0), (i == len - 1)});
      a = a + stride;
    end
  endtask

  task automatic idle_inputs();
    ub1.wr_en = 1'b0; ub1.wr_addr = '0; ub1.wr_data = '0; ub1.wr_be = '0;
    ub1.cmd_valid = '0; ub1.cmd_base = '0; ub1.cmd_len = '0; ub1.cmd_stride = '0;
    ub1.cmd_abort = '0; ub1.pause = '0;
    ub3.wr_en = 1'b0; ub3.wr_addr = '0; ub3.wr_data = '0; ub3.wr_be = '0;
    ub3.cmd_valid = '0; ub3.cmd_base = '0; ub3.cmd_len = '0; ub3.cmd_stride = '0;
    ub3.cmd_abort = '0; ub3.pause = '0;
  endtask

  initial begin
    int nb;
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst ready", 64'({ub1.cmd_ready, ub3.cmd_ready}), 64'hF);
    chk("rst busy", 64'({ub1.busy, ub3.busy}), 64'h0);
    chk("rst valid", 64'({ub1.rd_valid, ub3.rd_valid, ub1.rd_first, ub1.rd_last}), 64'h0);
    chk("rst data", ub1.rd_data[63:0] | ub1.rd_data[127:64] | ub3.rd_data[63:0], 64'h0);
    rst = 1'b0;
    @(negedge clk);

    // Fill every row with a distinct pattern, then rows 0..7 with 0x11*row.
    for (int r = 0; r < 256; r++) wr(8'(r), {4{8'(r), 8'(r) ^ 8'hA5}}, 8'hFF);
    for (int r = 0; r < 8; r++) wr(8'(r), {8{8'(r * 17)}}, 8'hFF);

    // Test 1: linear stream of 8, latency 1
    q0.delete();
    cmd1(0, 8'd0, 16'd8, 8'd1);
    @(negedge clk);
    ub1.cmd_valid = '0;
    chk("t1 ready run", 64'(ub1.cmd_ready[0]), 64'd0);
    repeat (7) @(negedge clk);
    chk("t1 ready last issue", 64'(ub1.cmd_ready[0]), 64'd0);
    @(negedge clk);
    chk("t1 ready back", 64'(ub1.cmd_ready[0]), 64'd1);
    qc = q0;
    chk_stream("t1", 8'd0, 8, 8'd1);
    if (qc.size() == 8) chk("t1 span", 64'(qc[7].cyc - qc[0].cyc), 64'd7);
    if (qc.size() == 8) chk("t1 row7", qc[7].data, 64'h7777_7777_7777_7777);
    repeat (2) @(negedge clk);
    chk("t1 idle valid", 64'(ub1.rd_valid[0]), 64'd0);
    chk("t1 data hold", ub1.rd_data[63:0], 64'h7777_7777_7777_7777);

    // Test 2: wrapping strided stream on port 0, length-1 stream on port 1
    q0.delete(); q1.delete();
    cmd1(0, 8'd250, 16'd10, 8'd3);
    cmd1(1, 8'd5, 16'd1, 8'd0);
    @(negedge clk);
    ub1.cmd_valid = '0;
    wait_idle("t2 done", 40);
    qc = q0;
    chk_stream("t2 p0", 8'd250, 10, 8'd3);
    if (qc.size() == 10) chk("t2 wrap row0", qc[2].data, 64'h0);
    qc = q1;
    chk_stream("t2 p1", 8'd5, 1, 8'd0);

    // Test 3: partial byte-enable write
    wr(8'd30, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    wr(8'd30, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F);
    q1.delete();
    cmd1(1, 8'd30, 16'd1, 8'd0);
    @(negedge clk);
    ub1.cmd_valid = '0;
    wait_idle("t3 done", 20);
    qc = q1;
    chk("t3 count", 64'(qc.size()), 64'd1);
    if (qc.size() == 1) chk("t3 merge", qc[0].data, 64'hFFFF_FFFF_AAAA_AAAA);

    // Test 4: read and write of row 4 in the same cycle
    q0.delete();
    cmd1(0, 8'd4, 16'd1, 8'd0);
    @(negedge clk);
    ub1.cmd_valid = '0;
    wr(8'd4, {8{8'h99}}, 8'hFF);
    wait_idle("t4 done", 20);
    chk("t4 count", 64'(q0.size()), 64'd1);
`ifdef UB_WR_BYPASS_EN
    if (q0.size() == 1) chk("t4 same-cycle", q0[0].data, {8{8'h99}});
`else
    if (q0.size() == 1) chk("t4 same-cycle", q0[0].data, {8{8'h44}});
`endif
    q0.delete();
    cmd1(0, 8'd4, 16'd1, 8'd0);
    @(negedge clk);
    ub1.cmd_valid = '0;
    wait_idle("t4 reread done", 20);
    chk("t4 reread count", 64'(q0.size()), 64'd1);
    if (q0.size() == 1) chk("t4 reread", q0[0].data, {8{8'h99}});

    // Test 5: pause on the latency-3 engine
    q3.delete();
    cmd3(8'd40, 16'd6, 8'd1);
    @(negedge clk);
    ub3.cmd_valid = '0;
    repeat (2) @(negedge clk);
    ub3.pause[0] = 1'b1;
    repeat (2) @(negedge clk);
    chk("t5 busy in pause", 64'(ub3.busy[0]), 64'd1);
    ub3.pause[0] = 1'b0;
    wait_idle("t5 done", 40);
    qc = q3;
    chk_stream("t5", 8'd40, 6, 8'd1);
    if (qc.size() == 6) begin
      chk("t5 gap b0-b1", 64'(qc[1].cyc - qc[0].cyc), 64'd1);
      chk("t5 gap b1-b2", 64'(qc[2].cyc - qc[1].cyc), 64'd3);
      chk("t5 gap b2-b5", 64'(qc[5].cyc - qc[2].cyc), 64'd3);
    end

    // Abort a long stream; the new command in the abort cycle must be dropped.
    q3.delete();
    cmd3(8'd0, 16'd100, 8'd1);
    @(negedge clk);
    ub3.cmd_valid = '0;
    repeat (10) @(negedge clk);
    ub3.cmd_abort[0] = 1'b1;
    cmd3(8'd0, 16'd5, 8'd1);
    nb = q3.size();
    @(negedge clk);
    ub3.cmd_abort = '0;
    ub3.cmd_valid = '0;
    chk("t5 beats before abort", 64'(nb), 64'd8);
    chk("t5 abort valid", 64'(ub3.rd_valid[0]), 64'd0);
    chk("t5 abort busy", 64'(ub3.busy[0]), 64'd0);
    chk("t5 abort ready", 64'(ub3.cmd_ready[0]), 64'd1);
    repeat (8) @(negedge clk);
    chk("t5 no late beats", 64'(q3.size()), 64'(nb));
    chk("t5 abort cmd dropped", 64'(ub3.busy[0]), 64'd0);

    // Test 6: reset in the middle of a stream
    cmd1(0, 8'd0, 16'd50, 8'd1);
    @(negedge clk);
    ub1.cmd_valid = '0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6 rst valid", 64'({ub1.rd_valid, ub1.rd_first, ub1.rd_last}), 64'h0);
    chk("t6 rst data", ub1.rd_data[63:0] | ub1.rd_data[127:64], 64'h0);
    chk("t6 rst ready", 64'(ub1.cmd_ready), 64'h3);
    chk("t6 rst busy", 64'(ub1.busy), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    q0.delete();
    cmd1(0, 8'd100, 16'd3, 8'd2);
    @(negedge clk);
    ub1.cmd_valid = '0;
    wait_idle("t6 done", 20);
    qc = q0;
    chk_stream("t6", 8'd100, 3, 8'd2);

    // Zero-length command: no beats, never busy.
    q1.delete();
    cmd1(1, 8'd9, 16'd0, 8'd1);
    @(negedge clk);
    ub1.cmd_valid = '0;
    chk("t6 len0 busy", 64'(ub1.busy[1]), 64'd0);
    chk("t6 len0 ready", 64'(ub1.cmd_ready[1]), 64'd1);
    repeat (5) @(negedge clk);
    chk("t6 len0 beats", 64'(q1.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
